// File: rtl/wb_arbiter.sv
// Two-master Wishbone-style arbiter with address decode to memory, keyboard and DMA slaves.
// Unmapped or unanswered cycles complete with an error so neither master can hang.
module wb_arbiter #(
    parameter logic [31:0] MEM_TOP  = 32'h0000_7FFF,
    parameter logic [31:0] DMA_BASE = 32'h0000_E000,
    parameter logic [31:0] KEY_BASE = 32'h0000_F000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_cyc,
    input  logic        m0_we,
    input  logic [3:0]  m0_strb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_data_i,
    output logic        m0_ack,
    output logic [31:0] m0_data_o,
    input  logic        m1_cyc,
    input  logic        m1_we,
    input  logic [3:0]  m1_strb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_data_i,
    output logic        m1_ack,
    output logic [31:0] m1_data_o,
    output logic        s_mem_cyc,
    output logic        s_key_cyc,
    output logic        s_dma_cyc,
    output logic        s_we,
    output logic [3:0]  s_strb,
    output logic [31:0] s_addr,
    output logic [31:0] s_data_o,
    input  logic        s_mem_ack,
    input  logic        s_key_ack,
    input  logic        s_dma_ack,
    input  logic [31:0] s_mem_data_i,
    input  logic [31:0] s_key_data_i,
    input  logic [31:0] s_dma_data_i,
    output logic        bus_err,
    output logic        err_master
);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        errm_q, errm_d;
    logic [2:0]  sel_q, sel_d;    // one-hot {dma, key, mem}
    logic [7:0]  cnt_q, cnt_d;

    logic        pick;
    logic        cur_cyc;
    logic        slv_ack;
    logic [31:0] slv_data;
    logic        ack_w;
    logic [31:0] rdata_w;

    // Memory wins over DMA, DMA over keyboard, when parameter regions overlap.
    function automatic logic [2:0] decode(input logic [31:0] a);
        if (a <= MEM_TOP)                     return 3'b001;
        else if (a[31:12] == DMA_BASE[31:12]) return 3'b100;
        else if (a[31:12] == KEY_BASE[31:12]) return 3'b010;
        else                                  return 3'b000;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            errm_q  <= 1'b0;
            sel_q   <= 3'b000;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            errm_q  <= errm_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        errm_d   = errm_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        pick     = 1'b0;
        ack_w    = 1'b0;
        rdata_w  = 32'h0;
        bus_err  = 1'b0;
        s_we     = 1'b0;
        s_strb   = 4'h0;
        s_addr   = 32'h0;
        s_data_o = 32'h0;

        cur_cyc  = gnt_q ? m1_cyc : m0_cyc;
        slv_ack  = |(sel_q & {s_dma_ack, s_key_ack, s_mem_ack});
        unique case (1'b1)
            sel_q[2]: slv_data = s_dma_data_i;
            sel_q[1]: slv_data = s_key_data_i;
            default:  slv_data = s_mem_data_i;
        endcase

        unique case (state_q)
            IDLE: begin
                if (m0_cyc || m1_cyc) begin
                    pick    = (m0_cyc && m1_cyc) ? ~last_q : m1_cyc;
                    gnt_d   = pick;
                    cnt_d   = 8'd0;
                    sel_d   = decode(pick ? m1_addr : m0_addr);
                    state_d = (sel_d != 3'b000) ? BUSY : ERR;
                end
            end
            BUSY: begin
                s_we     = gnt_q ? m1_we     : m0_we;
                s_strb   = gnt_q ? m1_strb   : m0_strb;
                s_addr   = gnt_q ? m1_addr   : m0_addr;
                s_data_o = gnt_q ? m1_data_i : m0_data_i;
                // An abort takes priority so a same-cycle ack is never delivered.
                if (!cur_cyc) begin
                    state_d = IDLE;
                end else if (slv_ack) begin
                    ack_w   = 1'b1;
                    rdata_w = slv_data;
                    last_d  = gnt_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TO_CNT) state_d = ERR;
                end
            end
            ERR: begin
                ack_w   = 1'b1;
                bus_err = 1'b1;
                errm_d  = gnt_q;
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_mem_cyc  = (state_q == BUSY) && sel_q[0];
    assign s_key_cyc  = (state_q == BUSY) && sel_q[1];
    assign s_dma_cyc  = (state_q == BUSY) && sel_q[2];

    assign m0_ack     = ack_w && !gnt_q;
    assign m1_ack     = ack_w &&  gnt_q;
    assign m0_data_o  = gnt_q ? 32'h0 : rdata_w;
    assign m1_data_o  = gnt_q ? rdata_w : 32'h0;

    assign err_master = (state_q == ERR) ? gnt_q : errm_q;

endmodule
